// File: rtl/ppu_pkg.sv
// Shared types for the PPU VRAM bus sequencer: bus-cycle states and access owner.
package ppu_pkg;

    localparam int VRAM_ADDR_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALE,
        ST_RD,
        ST_WR
    } vram_state_t;

    typedef enum logic {
        OWN_RND,
        OWN_CPU
    } vram_owner_t;

endpackage

// File: rtl/ppu_vram_arbiter.sv
// Arbitrates render fetch and CPU PPUDATA accesses onto the multiplexed VRAM bus.
// Grant in the ALE cycle, strobe the next cycle, valid/done the cycle after; requesters hold req until granted.
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int CPU_STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rnd_req,
    input  logic [VRAM_ADDR_W-1:0] rnd_addr,
    output logic                   rnd_grant,
    output logic                   rnd_valid,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [VRAM_ADDR_W-1:0] cpu_addr,
    input  logic [7:0]             cpu_wdata,
    output logic                   cpu_grant,
    output logic                   cpu_done,
    output logic [7:0]             rd_data,
    input  logic [7:0]             vram_data_in,
    output logic                   ale,
    output logic [5:0]             ppu_address_out,
    output logic [7:0]             vram_data_address_out,
    output logic                   n_r,
    output logic                   n_w
);

    localparam int CNT_W = (CPU_STARVE_LIMIT < 1) ? 1 : $clog2(CPU_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(CPU_STARVE_LIMIT);

    vram_state_t            r_state;
    vram_owner_t            r_owner;
    logic [VRAM_ADDR_W-1:0] r_addr;
    logic                   r_we;
    logic [7:0]             r_wdata;
    logic [CNT_W-1:0]       r_starve_cnt;
    logic                   r_rnd_valid;
    logic                   r_cpu_done;
    logic [7:0]             r_rd_data;

    logic w_arb;
    logic w_cpu_win;
    logic w_rnd_win;

    // Arbitration happens in IDLE and in the single RD/WR cycle, giving back-to-back accesses.
    assign w_arb     = (r_state == ST_IDLE) || (r_state == ST_RD) || (r_state == ST_WR);
    assign w_cpu_win = cpu_req && (!rnd_req || (r_starve_cnt == LIM));
    assign w_rnd_win = rnd_req && !w_cpu_win;

    assign rnd_grant = (r_state == ST_ALE) && (r_owner == OWN_RND);
    assign cpu_grant = (r_state == ST_ALE) && (r_owner == OWN_CPU);
    assign rnd_valid = r_rnd_valid;
    assign cpu_done  = r_cpu_done;
    assign rd_data   = r_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_RND;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= 8'h00;
            r_starve_cnt <= '0;
            r_rnd_valid  <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_rd_data    <= 8'h00;
        end else begin
            r_rnd_valid <= (r_state == ST_RD) && (r_owner == OWN_RND);
            r_cpu_done  <= ((r_state == ST_RD) || (r_state == ST_WR)) && (r_owner == OWN_CPU);
            if (r_state == ST_RD) begin
                r_rd_data <= vram_data_in;
            end

            if (r_state == ST_ALE) begin
                r_state <= r_we ? ST_WR : ST_RD;
            end else if (w_arb) begin
                if (w_cpu_win) begin
                    r_state <= ST_ALE;
                    r_owner <= OWN_CPU;
                    r_addr  <= cpu_addr;
                    r_we    <= cpu_we;
                    r_wdata <= cpu_wdata;
                end else if (w_rnd_win) begin
                    // Render fetches are reads regardless of anything else on the bus.
                    r_state <= ST_ALE;
                    r_owner <= OWN_RND;
                    r_addr  <= rnd_addr;
                    r_we    <= 1'b0;
                    r_wdata <= 8'h00;
                end else begin
                    r_state <= ST_IDLE;
                end
            end

            if (!cpu_req || cpu_grant) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != LIM) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ale                   = 1'b0;
        n_r                   = 1'b1;
        n_w                   = 1'b1;
        ppu_address_out       = 6'h00;
        vram_data_address_out = 8'h00;
        case (r_state)
            ST_ALE: begin
                ale                   = 1'b1;
                ppu_address_out       = r_addr[13:8];
                vram_data_address_out = r_addr[7:0];
            end
            ST_RD: begin
                n_r             = 1'b0;
                ppu_address_out = r_addr[13:8];
            end
            ST_WR: begin
                n_w                   = 1'b0;
                ppu_address_out       = r_addr[13:8];
                vram_data_address_out = r_wdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed and random checks of the VRAM arbiter; expected read data is queued at issue and popped on valid/done.
module tb_ppu_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rnd_req;
    logic [13:0] rnd_addr;
    logic        rnd_grant;
    logic        rnd_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_grant;
    logic        cpu_done;
    logic [7:0]  rd_data;
    logic [7:0]  vram_data_in;
    logic        ale;
    logic [5:0]  ppu_address_out;
    logic [7:0]  vram_data_address_out;
    logic        n_r;
    logic        n_w;

    always #5 clk = ~clk;

    ppu_vram_arbiter #(.CPU_STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_grant(rnd_grant), .rnd_valid(rnd_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .cpu_done(cpu_done), .rd_data(rd_data),
        .vram_data_in(vram_data_in), .ale(ale), .ppu_address_out(ppu_address_out),
        .vram_data_address_out(vram_data_address_out), .n_r(n_r), .n_w(n_w)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_val(input logic [13:0] a);
        if (a == 14'h0FF0) return 8'h3C;
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
    endfunction

    // VRAM model: latches the address on ALE, serves reads and absorbs writes.
    logic [7:0]  vmem [0:16383];
    logic [13:0] lat = 14'h0;
    assign vram_data_in = vmem[lat];

    always @(negedge clk) begin
        if (ale) lat <= {ppu_address_out, vram_data_address_out};
        if (!n_w) vmem[lat] <= vram_data_address_out;
    end

    typedef struct {
        bit         rd;
        logic [7:0] d;
    } cpu_exp_t;

    logic [7:0] rnd_q [$];
    cpu_exp_t   cpu_q [$];

    logic rg1 = 1'b0, rg2 = 1'b0, cg1 = 1'b0, cg2 = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            rg1 <= 1'b0; rg2 <= 1'b0; cg1 <= 1'b0; cg2 <= 1'b0;
        end else begin
            rg1 <= rnd_grant; rg2 <= rg1;
            cg1 <= cpu_grant; cg2 <= cg1;
            if (rnd_valid || rg2) chk("rnd_valid_2_after_grant", rnd_valid, rg2);
            if (cpu_done || cg2)  chk("cpu_done_2_after_grant", cpu_done, cg2);
            if (rnd_valid) begin
                chk("rnd_valid_expected", rnd_q.size() != 0, 1);
                if (rnd_q.size() != 0) chk("rnd_rd_data", rd_data, rnd_q.pop_front());
            end
            if (cpu_done) begin
                chk("cpu_done_expected", cpu_q.size() != 0, 1);
                if (cpu_q.size() != 0) begin
                    if (cpu_q[0].rd) chk("cpu_rd_data", rd_data, cpu_q[0].d);
                    void'(cpu_q.pop_front());
                end
            end
        end
        chk("strobes_not_both_low", (!n_r && !n_w), 0);
        chk("ale_only_with_strobes_high", (ale && !(n_r && n_w)), 0);
    end

    task automatic rnd_driver(input int n);
        logic [13:0] a;
        int t;
        for (int i = 0; i < n; i++) begin
            a = 14'($urandom_range(0, 14'h0FEF));
            rnd_addr = a;
            rnd_req  = 1'b1;
            rnd_q.push_back(exp_val(a));
            t = 0;
            do begin @(negedge clk); t++; end while (!rnd_grant && t < 100);
            chk("rnd_grant_in_time", rnd_grant, 1);
            if ($urandom_range(0, 1) == 0) begin
                rnd_req = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        rnd_req = 1'b0;
    endtask

    task automatic cpu_driver(input int n);
        logic [13:0] a;
        cpu_exp_t    e;
        int t;
        for (int i = 0; i < n; i++) begin
            e.rd = ($urandom_range(0, 1) == 0);
            // Writes land in a region never read back, so read expectations stay fixed.
            a = e.rd ? 14'(14'h1000 + $urandom_range(0, 14'h0FFF))
                     : 14'(14'h3000 + $urandom_range(0, 14'h0FFF));
            e.d       = exp_val(a);
            cpu_addr  = a;
            cpu_we    = !e.rd;
            cpu_wdata = 8'($urandom_range(0, 255));
            cpu_req   = 1'b1;
            cpu_q.push_back(e);
            t = 0;
            do begin @(negedge clk); t++; end while (!cpu_grant && t < 100);
            chk("cpu_grant_in_time", cpu_grant, 1);
            if ($urandom_range(0, 1) == 0) begin
                cpu_req = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        cpu_exp_t e;
        for (int i = 0; i < 16384; i++) vmem[i] = exp_val(14'(i));
        reset = 1'b1;
        rnd_req = 1'b0; rnd_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #1;
        chk("rst_ale", ale, 0);
        chk("rst_n_r", n_r, 1);
        chk("rst_n_w", n_w, 1);
        chk("rst_ppu_addr", ppu_address_out, 0);
        chk("rst_vda", vram_data_address_out, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_grants", {rnd_grant, cpu_grant, rnd_valid, cpu_done}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // CPU write 2105 <= A5 from idle
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2105; cpu_wdata = 8'hA5;
        e.rd = 1'b0; e.d = 8'h00; cpu_q.push_back(e);
        @(negedge clk);
        chk("wr_ale", ale, 1);
        chk("wr_grant", cpu_grant, 1);
        chk("wr_ale_ppu", ppu_address_out, 6'h21);
        chk("wr_ale_vda", vram_data_address_out, 8'h05);
        chk("wr_ale_strobes", {n_r, n_w}, 2'b11);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("wr_n_w", n_w, 0);
        chk("wr_n_r", n_r, 1);
        chk("wr_vda", vram_data_address_out, 8'hA5);
        chk("wr_ppu_held", ppu_address_out, 6'h21);
        @(negedge clk);
        chk("wr_done", cpu_done, 1);
        chk("wr_idle_bus", {ale, n_r, n_w, vram_data_address_out}, {1'b0, 1'b1, 1'b1, 8'h00});
        chk("wr_vram_written", vmem[14'h2105], 8'hA5);

        // Render 0FF0 then back-to-back 0123; a CPU request withdrawn before it can win
        rnd_req = 1'b1; rnd_addr = 14'h0FF0; rnd_q.push_back(8'h3C);
        @(negedge clk);
        chk("rnd_grant", rnd_grant, 1);
        chk("rnd_ale_ppu", ppu_address_out, 6'h0F);
        chk("rnd_ale_vda", vram_data_address_out, 8'hF0);
        rnd_addr = 14'h0123; rnd_q.push_back(exp_val(14'h0123));
        @(negedge clk);
        chk("rnd_n_r", n_r, 0);
        chk("rnd_rd_vda", vram_data_address_out, 8'h00);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3333; cpu_wdata = 8'hEE;
        @(negedge clk);
        chk("b2b_valid", rnd_valid, 1);
        chk("b2b_rd_data", rd_data, 8'h3C);
        chk("b2b_ale", ale, 1);
        chk("b2b_grant_rnd", rnd_grant, 1);
        chk("b2b_cpu_loses", cpu_grant, 0);
        chk("b2b_addr", {ppu_address_out, vram_data_address_out}, 14'h0123);
        rnd_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("b2b_n_r", n_r, 0);
        @(negedge clk);
        chk("b2b_valid2", rnd_valid, 1);
        chk("b2b_rd_data2", rd_data, 8'h78);

        // CPU read with render idle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
        e.rd = 1'b1; e.d = 8'h7C; cpu_q.push_back(e);
        @(negedge clk);
        chk("crd_grant", cpu_grant, 1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("crd_strobes", {n_r, n_w}, 2'b01);
        @(negedge clk);
        chk("crd_n_r_one_cycle", n_r, 1);
        chk("crd_done", cpu_done, 1);
        chk("crd_data", rd_data, 8'h7C);

        // Both held: render wins 4 times, then CPU once starve_cnt reaches 8
        rnd_req = 1'b1; rnd_addr = 14'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1100;
        for (int i = 0; i < 8; i++) rnd_q.push_back(8'h5B);
        e.rd = 1'b1; e.d = 8'h4B;
        cpu_q.push_back(e); cpu_q.push_back(e);
        for (int g = 0; g < 10; g++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!rnd_grant && !cpu_grant && t < 20);
            chk("starve_grant_is_cpu", cpu_grant, (g == 4 || g == 9) ? 1 : 0);
            if (cpu_grant) chk("starve_cnt_at_limit", dut.r_starve_cnt, 8);
            if (g == 9) begin rnd_req = 1'b0; cpu_req = 1'b0; end
            if (cpu_grant) begin
                @(negedge clk);
                chk("starve_cnt_cleared", dut.r_starve_cnt, 0);
            end
        end
        repeat (4) @(negedge clk);

        // Reset during RD discards the access
        rnd_req = 1'b1; rnd_addr = 14'h0200; rnd_q.push_back(exp_val(14'h0200));
        @(negedge clk);
        rnd_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_n_r", n_r, 0);
        #2;
        reset = 1'b1;
        rnd_q.delete();
        #1;
        chk("midrst_bus", {ale, n_r, n_w}, 3'b011);
        chk("midrst_rd_data", rd_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        rnd_req = 1'b1; rnd_addr = 14'h0345; rnd_q.push_back(8'h1C);
        @(negedge clk);
        chk("post_rst_grant", rnd_grant, 1);
        rnd_req = 1'b0;
        @(negedge clk);
        chk("post_rst_n_r", n_r, 0);
        @(negedge clk);
        chk("post_rst_valid", rnd_valid, 1);
        @(negedge clk);

        // Random interleaving
        fork
            rnd_driver(400);
            cpu_driver(400);
        join
        repeat (10) @(negedge clk);
        chk("rnd_q_drained", rnd_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
